// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator.
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Generator FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form.
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream data channel bundle.
interface axis_traffic_gen_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_traffic_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable.
module lfsr32_galois
  import axis_traffic_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // Load wins over advance; an all-zero seed would lock up, so it is replaced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= LFSR_DEFAULT_SEED;
    else if (load)
      state <= (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
    else if (advance)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: ramp / LFSR / constant packets with gaps.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start, outputs quiet
// ST_SEND   | presenting words of the current packet
// ST_GAP    | counting idle cycles between packets
// ST_FINISH | one-cycle done pulse, then back to idle
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [LEN_W-1:0]  gap,
  input  logic [DWIDTH-1:0] ramp_start,
  input  logic [DWIDTH-1:0] ramp_inc,
  input  logic [31:0]       lfsr_seed,
  axis_traffic_gen_if.master m,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_count
);

  logic [1:0]        state;
  mode_e             cfg_mode;
  logic [LEN_W-1:0]  cfg_last_idx;
  logic [CNT_W-1:0]  cfg_num;
  logic [LEN_W-1:0]  cfg_gap;
  logic [DWIDTH-1:0] cfg_rs;
  logic [DWIDTH-1:0] cfg_ri;
  logic [LEN_W-1:0]  word_left;
  logic [LEN_W-1:0]  gap_left;
  logic [DWIDTH-1:0] ramp_acc;
  logic              abort_pend;
  logic [31:0]       lfsr_state;
  logic [DWIDTH-1:0] lfsr_rep;

  logic start_ok, xfer, is_last, run_done, stop;

  assign start_ok = start && (state == ST_IDLE);
  assign xfer     = (state == ST_SEND) && m.tready;
  assign is_last  = (word_left == '0);
  assign run_done = (cfg_num != '0) && ((pkt_count + CNT_W'(1)) == cfg_num);
  assign stop     = abort_pend || abort || run_done;

  lfsr32_galois u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .seed    (lfsr_seed),
    .advance (xfer),
    .state   (lfsr_state)
  );

  // Run sequencing: config capture, word/gap down-counters, packet count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cfg_mode     <= MODE_RAMP;
      cfg_last_idx <= '0;
      cfg_num      <= '0;
      cfg_gap      <= '0;
      cfg_rs       <= '0;
      cfg_ri       <= '0;
      word_left    <= '0;
      gap_left     <= '0;
      ramp_acc     <= '0;
      abort_pend   <= 1'b0;
      pkt_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_mode     <= mode_e'(mode);
            cfg_last_idx <= (pkt_len == '0) ? '0 : pkt_len - LEN_W'(1);
            word_left    <= (pkt_len == '0) ? '0 : pkt_len - LEN_W'(1);
            cfg_num      <= num_pkts;
            cfg_gap      <= gap;
            cfg_rs       <= ramp_start;
            cfg_ri       <= ramp_inc;
            ramp_acc     <= ramp_start;
            abort_pend   <= 1'b0;
            pkt_count    <= '0;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (xfer) begin
            if (is_last) begin
              pkt_count <= pkt_count + CNT_W'(1);
              word_left <= cfg_last_idx;
              ramp_acc  <= cfg_rs;
              if (stop) begin
                state <= ST_FINISH;
              end else if (cfg_gap != '0) begin
                gap_left <= cfg_gap - LEN_W'(1);
                state    <= ST_GAP;
              end
            end else begin
              word_left <= word_left - LEN_W'(1);
              ramp_acc  <= ramp_acc + cfg_ri;
            end
          end
        end
        ST_GAP: begin
          if (abort || abort_pend) state <= ST_FINISH;
          else if (gap_left == '0) state <= ST_SEND;
          else gap_left <= gap_left - LEN_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LFSR word replicated across the full data width.
  always_comb begin
    lfsr_rep = '0;
    for (int i = 0; i < DWIDTH; i++) lfsr_rep[i] = lfsr_state[i % 32];
  end

  // Stream outputs come straight from registered state, so a stall holds them.
  always_comb begin
    m.tvalid = (state == ST_SEND);
    m.tlast  = m.tvalid && is_last;
    m.tdata  = '0;
    if (m.tvalid) begin
      case (cfg_mode)
        MODE_LFSR:  m.tdata = lfsr_rep;
        MODE_CONST: m.tdata = cfg_rs;
        default:    m.tdata = ramp_acc;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed and randomized checks of axis_traffic_gen against a packet-level model.
module tb_axis_traffic_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [1:0]  mode;
  logic [15:0] pkt_len, num_pkts, gap;
  logic [63:0] ramp_start, ramp_inc;
  logic [31:0] lfsr_seed;
  logic        busy, done;
  logic [15:0] pkt_count;

  int vectors = 0;
  int miscompares = 0;

  axis_traffic_gen_if #(.DWIDTH(64)) axis ();

  axis_traffic_gen #(.DWIDTH(64), .LEN_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .pkt_len    (pkt_len),
    .num_pkts   (num_pkts),
    .gap        (gap),
    .ramp_start (ramp_start),
    .ramp_inc   (ramp_inc),
    .lfsr_seed  (lfsr_seed),
    .m          (axis),
    .busy       (busy),
    .done       (done),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: shift right, fold the polynomial taps in when a 1 drops out.
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic scramble_cfg();
    mode       = 2'($urandom_range(0, 3));
    pkt_len    = 16'($urandom_range(0, 9));
    num_pkts   = 16'($urandom_range(0, 9));
    gap        = 16'($urandom_range(0, 9));
    ramp_start = {$urandom, $urandom};
    ramp_inc   = {$urandom, $urandom};
    lfsr_seed  = $urandom;
  endtask

  // rdy: 0 always ready, 1 toggle, 2 random. abort_pkt: packet index to abort in (-1 none).
  task automatic run(input logic [1:0] md, input int plen, input int npk, input int gp,
                     input logic [63:0] rs, input logic [63:0] ri, input logic [31:0] seed,
                     input int rdy, input int abort_pkt);
    int L, k, p, gcnt, phase, cyc;
    bit apend, fired;
    logic [31:0] lf;
    logic [63:0] expd;
    L = (plen == 0) ? 1 : plen;
    k = 0; p = 0; gcnt = 0; phase = 1; cyc = 0;
    apend = 1'b0; fired = 1'b0;
    lf = (seed == 32'h0) ? 32'h1 : seed;
    mode = md; pkt_len = 16'(plen); num_pkts = 16'(npk); gap = 16'(gp);
    ramp_start = rs; ramp_inc = ri; lfsr_seed = seed;
    start = 1'b1; abort = 1'b0; axis.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    check("busy after start", 64'(busy), 64'd1);
    while (phase != 4) begin
      if (cyc > 3000) begin
        check("run timeout busy", 64'(busy), 64'd0);
        break;
      end
      cyc++;
      case (rdy)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ~axis.tready;
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
      abort = 1'b0;
      start = 1'b0;
      case (phase)
        1: begin
          if (md == 2'd1)      expd = {lf, lf};
          else if (md == 2'd2) expd = rs;
          else                 expd = rs + 64'(k) * ri;
          check("tvalid", 64'(axis.tvalid), 64'd1);
          check("tdata", axis.tdata, expd);
          check("tlast", 64'(axis.tlast), 64'(k == L - 1));
          check("done idle", 64'(done), 64'd0);
          check("pkt_count run", 64'(pkt_count), 64'(p));
          if (p == abort_pkt && k == 1 && !fired) begin
            abort = 1'b1; start = 1'b1; apend = 1'b1; fired = 1'b1;
          end
          if (axis.tready) begin
            lf = ref_lfsr(lf);
            if (k == L - 1) begin
              p++; k = 0;
              if (apend || (npk != 0 && p == npk)) phase = 3;
              else if (gp > 0) begin phase = 2; gcnt = gp; end
            end else begin
              k++;
            end
          end
        end
        2: begin
          check("gap idle", 64'(axis.tvalid), 64'd0);
          check("done gap", 64'(done), 64'd0);
          gcnt--;
          if (gcnt == 0) phase = 1;
        end
        default: begin
          check("done pulse", 64'(done), 64'd1);
          check("tvalid finish", 64'(axis.tvalid), 64'd0);
          check("pkt_count end", 64'(pkt_count), 64'(p));
          start = 1'b1;
          phase = 4;
        end
      endcase
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    check("done cleared", 64'(done), 64'd0);
    check("busy cleared", 64'(busy), 64'd0);
    @(negedge clk);
    check("start with done ignored", 64'(axis.tvalid), 64'd0);
    check("pkt_count held", 64'(pkt_count), 64'(p));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; axis.tready = 1'b0;
    mode = 2'd0; pkt_len = '0; num_pkts = '0; gap = '0;
    ramp_start = '0; ramp_inc = '0; lfsr_seed = '0;
    #1;
    check("rst tvalid", 64'(axis.tvalid), 64'd0);
    check("rst tdata", axis.tdata, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst pkt_count", 64'(pkt_count), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run(2'd0, 4, 1, 0, 64'd10, 64'd3, 32'd0, 0, -1);
    run(2'd0, 3, 2, 0, 64'd100, 64'd1, 32'd0, 0, -1);
    run(2'd0, 3, 3, 2, {$urandom, $urandom}, {$urandom, $urandom}, 32'd0, 1, -1);
    run(2'd0, 0, 3, 0, '1, 64'd1, 32'd0, 0, -1);
    run(2'd0, 2, 2, 0, '1, 64'd1, 32'd0, 0, -1);
    run(2'd2, 3, 2, 1, 64'hDEAD_BEEF_0123_4567, 64'd5, 32'd0, 2, -1);
    run(2'd3, 4, 2, 0, 64'd7, 64'd9, 32'd0, 2, -1);
    run(2'd1, 5, 3, 1, 64'd0, 64'd0, 32'hACE1_1234, 2, -1);
    run(2'd1, 3, 2, 0, 64'd0, 64'd0, 32'd0, 0, -1);
    run(2'd0, 5, 0, 1, 64'd50, 64'd2, 32'd0, 2, 2);

    // Async reset mid-packet, between clock edges.
    mode = 2'd1; pkt_len = 16'd2; num_pkts = 16'd0; gap = 16'd0;
    lfsr_seed = 32'h1357_9BDF; axis.tready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async rst tvalid", 64'(axis.tvalid), 64'd0);
    check("async rst tlast", 64'(axis.tlast), 64'd0);
    check("async rst tdata", axis.tdata, 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst pkt_count", 64'(pkt_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("no done after reset", 64'(done), 64'd0);
    run(2'd1, 4, 3, 2, 64'd0, 64'd0, 32'h1357_9BDF, 2, -1);

    for (int r = 0; r < 8; r++)
      run(2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom_range(1, 4),
          $urandom_range(0, 3), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
